// File: rtl/mult4x4_seg7_display.sv
// mult4x4_seg7_display: registered WIDTH x WIDTH multiply shown as three active-low 7-segment digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module mult4x4_seg7_display #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [6:0]       out1,
   output logic [6:0]       out2,
   output logic [6:0]       out3
);
   if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
      $error("mult4x4_seg7_display: WIDTH must be 1..4 so the product fits three digits");
   end
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   function automatic logic [11:0] to_bcd(input logic [7:0] v);
      logic [19:0] s;
      s = {12'd0, v};
      for (int i = 0; i < 8; i++) begin
         s[11:8]  = (s[11:8]  >= 4'd5) ? s[11:8]  + 4'd3 : s[11:8];
         s[15:12] = (s[15:12] >= 4'd5) ? s[15:12] + 4'd3 : s[15:12];
         s[19:16] = (s[19:16] >= 4'd5) ? s[19:16] + 4'd3 : s[19:16];
         s = s << 1;
      end
      return s[19:8];
   endfunction
   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b0111111;
      endcase
   endfunction
   logic [WIDTH-1:0] a_q, b_q;
   logic [7:0]       p;
   logic [11:0]      bcd;
   logic [6:0]       n1, n2, n3;
   always_comb begin
      p   = 8'(a_q) * 8'(b_q);
      bcd = to_bcd(p);
      n1  = seg(bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
      n2  = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg(bcd[7:4]);
      n3  = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg(bcd[11:8]);
`else
      n2  = seg(bcd[7:4]);
      n3  = seg(bcd[11:8]);
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         out1 <= SEG_ZERO;
`ifdef LEADING_ZERO_BLANK_EN
         out2 <= SEG_BLANK;
         out3 <= SEG_BLANK;
`else
         out2 <= SEG_ZERO;
         out3 <= SEG_ZERO;
`endif
      end else begin
         a_q  <= A;
         b_q  <= B;
         out1 <= n1;
         out2 <= n2;
         out3 <= n3;
      end
   end
endmodule

// File: tb/tb_mult4x4_seg7_display.sv
// tb_mult4x4_seg7_display: directed and sweep checks of the multiplier display pipeline.
module tb_mult4x4_seg7_display;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] A, B;
   logic [6:0] out1, out2, out3;
   int passed = 0;
   int total  = 0;
   int failed = 0;
   int sa [8] = '{3, 15, 0, 9, 7, 15, 1, 12};
   int sb [8] = '{4, 15, 5, 9, 8, 14, 1, 13};
   logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   mult4x4_seg7_display #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .out1(out1), .out2(out2), .out3(out3)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask
   task automatic check_p(input string tag, input int p);
      logic [6:0] e3, e2;
      e3 = tbl[p / 100];
      e2 = tbl[(p / 10) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (p < 100) e3 = 7'b1111111;
      if (p < 10) e2 = 7'b1111111;
`endif
      check({tag, ".ones"}, out1, tbl[p % 10]);
      check({tag, ".tens"}, out2, e2);
      check({tag, ".hund"}, out3, e3);
   endtask
   task automatic step(input int a, input int b);
      A = 4'(a);
      B = 4'(b);
      repeat (2) @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1;
      A = 4'd9;
      B = 4'd9;
      repeat (2) @(posedge clk);
      #1;
      check("reset.ones", out1, 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
      check("reset.tens", out2, 7'b1111111);
      check("reset.hund", out3, 7'b1111111);
`else
      check("reset.tens", out2, 7'b1000000);
      check("reset.hund", out3, 7'b1000000);
`endif
      rst = 1'b0;
      step(0, 0);
      check_p("zero", 0);
      step(3, 4);
      check("p12.ones", out1, 7'b0100100);
      check("p12.tens", out2, 7'b1111001);
`ifdef LEADING_ZERO_BLANK_EN
      check("p12.hund", out3, 7'b1111111);
`else
      check("p12.hund", out3, 7'b1000000);
`endif
      step(11, 11);
      check("p121.ones", out1, 7'b1111001);
      check("p121.tens", out2, 7'b0100100);
      check("p121.hund", out3, 7'b1111001);
      step(15, 15);
      check("p225.ones", out1, 7'b0010010);
      check("p225.tens", out2, 7'b0100100);
      check("p225.hund", out3, 7'b0100100);
      step(0, 13);
      check_p("zero_x", 0);
      // Back-to-back stream: the value shown now belongs to inputs driven two edges ago.
      for (int i = 0; i < 10; i++) begin
         if (i >= 2) check_p($sformatf("stream%0d", i - 2), sa[i-2] * sb[i-2]);
         if (i < 8) begin
            A = 4'(sa[i]);
            B = 4'(sb[i]);
         end
         @(posedge clk);
         #1;
      end
      A = 4'd7;
      B = 4'd8;
      @(posedge clk);
      #1;
      A = 4'd15;
      B = 4'd15;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_p("midrst", 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      A = 4'd9;
      B = 4'd9;
      @(posedge clk);
      #1;
      check_p("postrst1", 0);
      @(posedge clk);
      #1;
      check_p("postrst2", 81);
      for (int i = 0; i < 258; i++) begin
         if (i >= 2) check_p($sformatf("sweep%0dx%0d", (i - 2) >> 4, (i - 2) & 15),
                             ((i - 2) >> 4) * ((i - 2) & 15));
         if (i < 256) begin
            A = 4'(i >> 4);
            B = 4'(i & 15);
         end
         @(posedge clk);
         #1;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
